// File: rtl/valu_pkg.sv
// Shared definitions for the vector ALU issue/retire sequencer.
// Holds the ALU opcode constants, the default vector geometry, the packed
// vector type and the sequencer state encoding.
package valu_pkg;

    localparam int unsigned DATA_WIDTH    = 8;
    localparam int unsigned LANES         = 8;
    localparam int unsigned SELECTOR_SIZE = 4;

    localparam logic [SELECTOR_SIZE-1:0] OP_VADD  = 4'b0100;
    localparam logic [SELECTOR_SIZE-1:0] OP_VADDI = 4'b1100;
    localparam logic [SELECTOR_SIZE-1:0] OP_VSUB  = 4'b1101;
    localparam logic [SELECTOR_SIZE-1:0] OP_VFMUL = 4'b0101;

    typedef logic [LANES-1:0][DATA_WIDTH-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } issue_state_e;

endpackage

// File: rtl/valu_issue_perf.sv
// Performance counters for the vector ALU sequencer.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   wb_valid     writeback result presented
//   wb_ready     writeback consumes the result
//   perf_ops     count of writeback handshakes (wraps at 2^32)
//   perf_stall   count of cycles with wb_valid=1 and wb_ready=0 (wraps at 2^32)
module valu_issue_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (wb_valid && wb_ready) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (wb_valid && !wb_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end

endmodule

// File: rtl/valu_issue_ctrl.sv
// Issue/retire sequencer for the vector ALU.
// Accepts one op from decode (in_valid/in_ready), registers selector and
// operands onto alu_sel/alu_a/alu_b, holds them for an opcode-dependent
// latency, captures alu_out and offers it to writeback (wb_valid/wb_ready).
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   in_valid/in_ready          decode handshake; in_op, in_rd, in_a, in_b payload
//   alu_sel, alu_a, alu_b      registered drive to the combinational ALU
//   alu_out                    ALU result
//   wb_valid/wb_ready          writeback handshake; wb_rd, wb_data payload
//   busy                       sequencer not idle
//   perf_ops, perf_stall       performance counters (only with VALU_ISSUE_PERF_EN)
// Optional feature macro: VALU_ISSUE_PERF_EN.
module valu_issue_ctrl
    import valu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = valu_pkg::DATA_WIDTH,
    parameter int unsigned LANES         = valu_pkg::LANES,
    parameter int unsigned SELECTOR_SIZE = valu_pkg::SELECTOR_SIZE,
    parameter int unsigned REG_AW        = 4,
    parameter int unsigned ADD_LAT       = 1,
    parameter int unsigned MUL_LAT       = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [SELECTOR_SIZE-1:0]         in_op,
    input  logic [REG_AW-1:0]                in_rd,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] in_a,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] in_b,
    output logic [SELECTOR_SIZE-1:0]         alu_sel,
    output logic [LANES-1:0][DATA_WIDTH-1:0] alu_a,
    output logic [LANES-1:0][DATA_WIDTH-1:0] alu_b,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] alu_out,
    output logic                             wb_valid,
    input  logic                             wb_ready,
    output logic [REG_AW-1:0]                wb_rd,
    output logic [LANES-1:0][DATA_WIDTH-1:0] wb_data,
`ifdef VALU_ISSUE_PERF_EN
    output logic [31:0]                      perf_ops,
    output logic [31:0]                      perf_stall,
`endif
    output logic                             busy
);

    localparam int unsigned MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    issue_state_e      state;
    logic [CNT_W-1:0]  cnt;
    logic [REG_AW-1:0] rd_reg;
    logic              accept;

    // Cycles left after the accept edge; unknown opcodes take the add latency.
    function automatic logic [CNT_W-1:0] lat_m1(input logic [SELECTOR_SIZE-1:0] op);
        if (op == OP_VFMUL) begin
            return CNT_W'(MUL_LAT - 1);
        end
        return CNT_W'(ADD_LAT - 1);
    endfunction

    assign in_ready = (state == IDLE) || ((state == HOLD) && wb_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rd_reg   <= '0;
            alu_sel  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_sel <= in_op;
                        alu_a   <= in_a;
                        alu_b   <= in_b;
                        rd_reg  <= in_rd;
                        cnt     <= lat_m1(in_op);
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        wb_data  <= alu_out;
                        wb_rd    <= rd_reg;
                        wb_valid <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        // Retire and accept share this edge when decode is waiting.
                        if (in_valid) begin
                            alu_sel <= in_op;
                            alu_a   <= in_a;
                            alu_b   <= in_b;
                            rd_reg  <= in_rd;
                            cnt     <= lat_m1(in_op);
                            state   <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VALU_ISSUE_PERF_EN
    valu_issue_perf u_perf (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall)
    );
`endif

endmodule

// File: tb/tb_valu_issue_ctrl.sv
// Directed self-checking bench for valu_issue_ctrl with a behavioural ALU.
module tb_valu_issue_ctrl;
    import valu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [3:0] in_rd;
    vec_t       in_a;
    vec_t       in_b;
    logic [3:0] alu_sel;
    vec_t       alu_a;
    vec_t       alu_b;
    vec_t       alu_out;
    logic       wb_valid;
    logic       wb_ready;
    logic [3:0] wb_rd;
    vec_t       wb_data;
    logic       busy;
`ifdef VALU_ISSUE_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;
`endif

    int checks;
    int passed;

    valu_issue_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_a     (in_a),
        .in_b     (in_b),
        .alu_sel  (alu_sel),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_out  (alu_out),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
`ifdef VALU_ISSUE_PERF_EN
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall),
`endif
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural vector ALU; the multiply is a lane-wise integer stand-in.
    always_comb begin
        alu_out = alu_a;
        for (int i = 0; i < LANES; i++) begin
            case (alu_sel)
                OP_VADD, OP_VADDI: alu_out[i] = alu_a[i] + alu_b[i];
                OP_VSUB:           alu_out[i] = alu_a[i] - alu_b[i];
                OP_VFMUL:          alu_out[i] = alu_a[i] * alu_b[i];
                default:           alu_out[i] = alu_a[i];
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] rd,
                         input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_a     = {LANES{a}};
        in_b     = {LANES{b}};
    endtask

    task automatic test_reset();
        bit stray;
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got %b want 0", wb_valid);
        else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else passed++;
        checks++; if (wb_data !== '0 || wb_rd !== 4'd0 || alu_sel !== 4'd0 || alu_a !== '0)
            $display("FAIL reset_regs got data %h rd %h sel %h a %h want zeros",
                     wb_data, wb_rd, alu_sel, alu_a);
        else passed++;
        rst_n = 1'b1;
        tick();
        // Start a multiply and kill it two cycles into EXEC.
        drive(OP_VFMUL, 4'd9, 8'h02, 8'h02);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b1) $display("FAIL reset_pre_busy got %b want 1", busy);
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_async got wb_valid %b busy %b want 0 0", wb_valid, busy);
        else passed++;
        tick();
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (5) begin
            tick();
            if (wb_valid !== 1'b0) stray = 1'b1;
        end
        checks++; if (stray) $display("FAIL reset_stray got wb_valid 1 want 0");
        else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_add();
        wb_ready = 1'b1;
        drive(4'b0100, 4'd7, 8'h05, 8'h03);
        tick();
        in_valid = 1'b0;
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL add_exec got wb_valid %b busy %b in_ready %b want 0 1 0",
                     wb_valid, busy, in_ready);
        else passed++;
        checks++; if (alu_sel !== 4'b0100 || alu_a !== {LANES{8'h05}} || alu_b !== {LANES{8'h03}})
            $display("FAIL add_alu_regs got sel %h a %h b %h", alu_sel, alu_a, alu_b);
        else passed++;
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_data !== {LANES{8'h08}} || wb_rd !== 4'd7)
            $display("FAIL add_result got valid %b data %h rd %0d want 1 %h 7",
                     wb_valid, wb_data, wb_rd, {LANES{8'h08}});
        else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL add_hold_ready got %b want 1", in_ready);
        else passed++;
        tick();
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL add_retire got wb_valid %b busy %b want 0 0", wb_valid, busy);
        else passed++;
    endtask

    task automatic test_sub_wrap();
        wb_ready = 1'b1;
        drive(4'b1101, 4'd1, 8'h03, 8'h05);
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_data !== {LANES{8'hFE}} || wb_rd !== 4'd1)
            $display("FAIL sub_wrap got valid %b data %h rd %0d want 1 %h 1",
                     wb_valid, wb_data, wb_rd, {LANES{8'hFE}});
        else passed++;
        tick();
    endtask

    task automatic test_fmul_latency();
        wb_ready = 1'b1;
        drive(4'b0101, 4'd4, 8'h03, 8'h04);
        tick();
        in_valid = 1'b0;
        in_a = {LANES{8'hFF}};
        in_b = {LANES{8'hFF}};
        for (int e = 1; e <= 2; e++) begin
            checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b0)
                $display("FAIL fmul_exec_%0d got wb_valid %b in_ready %b want 0 0",
                         e, wb_valid, in_ready);
            else passed++;
            checks++; if (alu_sel !== 4'b0101 || alu_a !== {LANES{8'h03}} ||
                          alu_b !== {LANES{8'h04}})
                $display("FAIL fmul_stable_%0d got sel %h a %h b %h", e, alu_sel, alu_a, alu_b);
            else passed++;
            tick();
        end
        checks++; if (wb_valid !== 1'b0) $display("FAIL fmul_early got wb_valid 1 want 0");
        else passed++;
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_data !== {LANES{8'h0C}} || wb_rd !== 4'd4)
            $display("FAIL fmul_result got valid %b data %h rd %0d want 1 %h 4",
                     wb_valid, wb_data, wb_rd, {LANES{8'h0C}});
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        wb_ready = 1'b0;
        drive(OP_VADD, 4'd3, 8'h10, 8'h01);
        tick();
        in_valid = 1'b0;
        tick();
        repeat (4) begin
            checks++; if (wb_valid !== 1'b1 || wb_data !== {LANES{8'h11}} || wb_rd !== 4'd3 ||
                          in_ready !== 1'b0)
                $display("FAIL bp_hold got valid %b data %h rd %0d in_ready %b want 1 %h 3 0",
                         wb_valid, wb_data, wb_rd, in_ready, {LANES{8'h11}});
            else passed++;
            tick();
        end
        wb_ready = 1'b1;
        drive(OP_VSUB, 4'd5, 8'h09, 8'h02);
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready got %b want 1", in_ready);
        else passed++;
        tick();
        in_valid = 1'b0;
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b1 || alu_sel !== OP_VSUB)
            $display("FAIL bp_overlap got valid %b busy %b sel %h want 0 1 %h",
                     wb_valid, busy, alu_sel, OP_VSUB);
        else passed++;
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_data !== {LANES{8'h07}} || wb_rd !== 4'd5)
            $display("FAIL bp_second got valid %b data %h rd %0d want 1 %h 5",
                     wb_valid, wb_data, wb_rd, {LANES{8'h07}});
        else passed++;
        tick();
    endtask

    task automatic test_unknown_op();
        wb_ready = 1'b1;
        drive(4'b0000, 4'd2, 8'hA5, 8'h11);
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_data !== {LANES{8'hA5}} || wb_rd !== 4'd2)
            $display("FAIL unknown_op got valid %b data %h rd %0d want 1 %h 2",
                     wb_valid, wb_data, wb_rd, {LANES{8'hA5}});
        else passed++;
        tick();
    endtask

`ifdef VALU_ISSUE_PERF_EN
    task automatic test_perf();
        // Six completed handshakes since the last reset; four stalled cycles.
        checks++; if (perf_ops !== 32'd6) $display("FAIL perf_ops got %0d want 6", perf_ops);
        else passed++;
        checks++; if (perf_stall !== 32'd4)
            $display("FAIL perf_stall got %0d want 4", perf_stall);
        else passed++;
    endtask
`endif

    initial begin
        checks   = 0;
        passed   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = '0;
        in_rd    = '0;
        in_a     = '0;
        in_b     = '0;
        wb_ready = 1'b0;
        test_reset();
        test_add();
        test_sub_wrap();
        test_fmul_latency();
        test_back_to_back();
        test_unknown_op();
`ifdef VALU_ISSUE_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
